// File: rtl/muldiv_ctrl.sv
// Sequencer between the control unit and the shared mult/div units.
// It latches the operands, holds each unit's start level until done, and owns the architectural HI/LO registers.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready; accepts one HI/LO-class instruction per cycle
// MUL_RUN | MultCtrl held high, waiting for MultDone or timeout
// DIV_RUN | DivCtrl held high, waiting for Div0, DivDone or timeout
// RELEASE | one cycle with both start levels low before returning to IDLE
module muldiv_ctrl #(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_W          = 7
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        op_valid,
   input  logic [2:0]  op_code,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output logic        op_ready,
   output logic [31:0] RegAOut,
   output logic [31:0] RegBOut,
   output logic        MultCtrl,
   input  logic        MultDone,
   input  logic [31:0] mult_hi,
   input  logic [31:0] mult_lo,
   output logic        DivCtrl,
   input  logic        DivDone,
   input  logic        Div0,
   input  logic [31:0] div_hi,
   input  logic [31:0] div_lo,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] mf_data,
   output logic        mf_valid,
   output logic        op_done,
   output logic        div0_exc,
   output logic        timeout_err,
   output logic        illegal_op
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MUL_RUN = 2'd1,
      DIV_RUN = 2'd2,
      RELEASE = 2'd3
   } state_t;

   localparam logic [2:0] OP_MULT = 3'd1;
   localparam logic [2:0] OP_DIV  = 3'd2;
   localparam logic [2:0] OP_MFHI = 3'd3;
   localparam logic [2:0] OP_MFLO = 3'd4;
   localparam logic [2:0] OP_MTHI = 3'd5;
   localparam logic [2:0] OP_MTLO = 3'd6;
   localparam logic [2:0] OP_ILL  = 3'd7;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           r_state, w_state_nxt;
   logic [31:0]      r_hi, r_lo, r_a, r_b, r_mf_data;
   logic [31:0]      w_hi_nxt, w_lo_nxt, w_a_nxt, w_b_nxt, w_mf_data_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic             r_mult_ctrl, r_div_ctrl, w_mult_ctrl_nxt, w_div_ctrl_nxt;
   logic             r_mf_valid, r_op_done, r_div0, r_timeout, r_illegal;
   logic             w_mf_valid_nxt, w_op_done_nxt, w_div0_nxt, w_timeout_nxt, w_illegal_nxt;
   logic             w_accept;

   assign w_accept = op_valid && (r_state == IDLE);

   always_comb begin
      w_state_nxt     = r_state;
      w_hi_nxt        = r_hi;
      w_lo_nxt        = r_lo;
      w_a_nxt         = r_a;
      w_b_nxt         = r_b;
      w_mf_data_nxt   = r_mf_data;
      w_cnt_nxt       = r_cnt;
      w_mult_ctrl_nxt = r_mult_ctrl;
      w_div_ctrl_nxt  = r_div_ctrl;
      w_mf_valid_nxt  = 1'b0;
      w_op_done_nxt   = 1'b0;
      w_div0_nxt      = 1'b0;
      w_timeout_nxt   = 1'b0;
      w_illegal_nxt   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               case (op_code)
                  OP_MULT: begin
                     w_a_nxt         = rs_val;
                     w_b_nxt         = rt_val;
                     w_cnt_nxt       = '0;
                     w_mult_ctrl_nxt = 1'b1;
                     w_state_nxt     = MUL_RUN;
                  end
                  OP_DIV: begin
                     w_a_nxt        = rs_val;
                     w_b_nxt        = rt_val;
                     w_cnt_nxt      = '0;
                     w_div_ctrl_nxt = 1'b1;
                     w_state_nxt    = DIV_RUN;
                  end
                  OP_MFHI: begin
                     w_mf_data_nxt  = r_hi;
                     w_mf_valid_nxt = 1'b1;
                  end
                  OP_MFLO: begin
                     w_mf_data_nxt  = r_lo;
                     w_mf_valid_nxt = 1'b1;
                  end
                  OP_MTHI: w_hi_nxt = rs_val;
                  OP_MTLO: w_lo_nxt = rs_val;
                  OP_ILL:  w_illegal_nxt = 1'b1;
                  default: ;
               endcase
            end
         end
         MUL_RUN: begin
            w_cnt_nxt = r_cnt + 1'b1;
            if (MultDone) begin
               w_hi_nxt        = mult_hi;
               w_lo_nxt        = mult_lo;
               w_op_done_nxt   = 1'b1;
               w_mult_ctrl_nxt = 1'b0;
               w_state_nxt     = RELEASE;
            end else if (r_cnt == CNT_LAST) begin
               w_timeout_nxt   = 1'b1;
               w_op_done_nxt   = 1'b1;
               w_mult_ctrl_nxt = 1'b0;
               w_state_nxt     = RELEASE;
            end
         end
         DIV_RUN: begin
            w_cnt_nxt = r_cnt + 1'b1;
            // Div0 outranks DivDone: a zero divisor never updates HI/LO.
            if (Div0) begin
               w_div0_nxt     = 1'b1;
               w_op_done_nxt  = 1'b1;
               w_div_ctrl_nxt = 1'b0;
               w_state_nxt    = RELEASE;
            end else if (DivDone) begin
               w_hi_nxt       = div_hi;
               w_lo_nxt       = div_lo;
               w_op_done_nxt  = 1'b1;
               w_div_ctrl_nxt = 1'b0;
               w_state_nxt    = RELEASE;
            end else if (r_cnt == CNT_LAST) begin
               w_timeout_nxt  = 1'b1;
               w_op_done_nxt  = 1'b1;
               w_div_ctrl_nxt = 1'b0;
               w_state_nxt    = RELEASE;
            end
         end
         RELEASE: begin
            w_mult_ctrl_nxt = 1'b0;
            w_div_ctrl_nxt  = 1'b0;
            w_state_nxt     = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_hi        <= '0;
         r_lo        <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_mf_data   <= '0;
         r_cnt       <= '0;
         r_mult_ctrl <= 1'b0;
         r_div_ctrl  <= 1'b0;
         r_mf_valid  <= 1'b0;
         r_op_done   <= 1'b0;
         r_div0      <= 1'b0;
         r_timeout   <= 1'b0;
         r_illegal   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_hi        <= w_hi_nxt;
         r_lo        <= w_lo_nxt;
         r_a         <= w_a_nxt;
         r_b         <= w_b_nxt;
         r_mf_data   <= w_mf_data_nxt;
         r_cnt       <= w_cnt_nxt;
         r_mult_ctrl <= w_mult_ctrl_nxt;
         r_div_ctrl  <= w_div_ctrl_nxt;
         r_mf_valid  <= w_mf_valid_nxt;
         r_op_done   <= w_op_done_nxt;
         r_div0      <= w_div0_nxt;
         r_timeout   <= w_timeout_nxt;
         r_illegal   <= w_illegal_nxt;
      end
   end

   assign op_ready    = (r_state == IDLE);
   assign RegAOut     = r_a;
   assign RegBOut     = r_b;
   assign MultCtrl    = r_mult_ctrl;
   assign DivCtrl     = r_div_ctrl;
   assign HI          = r_hi;
   assign LO          = r_lo;
   assign mf_data     = r_mf_data;
   assign mf_valid    = r_mf_valid;
   assign op_done     = r_op_done;
   assign div0_exc    = r_div0;
   assign timeout_err = r_timeout;
   assign illegal_op  = r_illegal;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl; expected values are hand-computed constants.
module tb_muldiv_ctrl;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        op_valid = 1'b0;
   logic [2:0]  op_code = '0;
   logic [31:0] rs_val = '0, rt_val = '0;
   logic        op_ready, MultCtrl, DivCtrl;
   logic [31:0] RegAOut, RegBOut, HI, LO, mf_data;
   logic        MultDone = 1'b0, DivDone = 1'b0, Div0 = 1'b0;
   logic [31:0] mult_hi = '0, mult_lo = '0, div_hi = '0, div_lo = '0;
   logic        mf_valid, op_done, div0_exc, timeout_err, illegal_op;
   int          checks = 0;
   int          failures = 0;

   muldiv_ctrl #(.TIMEOUT_CYCLES(8), .CNT_W(7)) dut (
      .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
      .rs_val(rs_val), .rt_val(rt_val), .op_ready(op_ready),
      .RegAOut(RegAOut), .RegBOut(RegBOut),
      .MultCtrl(MultCtrl), .MultDone(MultDone), .mult_hi(mult_hi), .mult_lo(mult_lo),
      .DivCtrl(DivCtrl), .DivDone(DivDone), .Div0(Div0), .div_hi(div_hi), .div_lo(div_lo),
      .HI(HI), .LO(LO), .mf_data(mf_data), .mf_valid(mf_valid), .op_done(op_done),
      .div0_exc(div0_exc), .timeout_err(timeout_err), .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b);
      op_valid = 1'b1;
      op_code  = code;
      rs_val   = a;
      rt_val   = b;
   endtask

   initial begin
      // reset state
      tick(); tick();
      chk("rst_op_ready", 32'(op_ready), 32'd1);
      chk("rst_hi", HI, 32'd0);
      chk("rst_lo", LO, 32'd0);
      chk("rst_rega", RegAOut, 32'd0);
      chk("rst_ctrl", {30'd0, MultCtrl, DivCtrl}, 32'd0);
      chk("rst_pulses", {27'd0, mf_valid, op_done, div0_exc, timeout_err, illegal_op}, 32'd0);
      reset = 1'b1;
      tick();

      // MTHI then MFHI the next cycle, then MFLO
      issue(3'd5, 32'hDEADBEEF, 32'd0);
      tick();
      chk("mthi_hi", HI, 32'hDEADBEEF);
      chk("mthi_no_mf", 32'(mf_valid), 32'd0);
      issue(3'd3, 32'd0, 32'd0);
      tick();
      chk("mfhi_valid", 32'(mf_valid), 32'd1);
      chk("mfhi_data", mf_data, 32'hDEADBEEF);
      issue(3'd4, 32'd0, 32'd0);
      tick();
      chk("mflo_valid", 32'(mf_valid), 32'd1);
      chk("mflo_data", mf_data, 32'd0);
      issue(3'd7, 32'h12345678, 32'd0);
      tick();
      chk("mf_pulse_end", 32'(mf_valid), 32'd0);
      chk("illegal_pulse", 32'(illegal_op), 32'd1);
      chk("illegal_no_fx", HI, 32'hDEADBEEF);
      op_valid = 1'b0;
      tick();
      chk("illegal_end", 32'(illegal_op), 32'd0);

      // DIV 10/3, done on 5th run cycle
      issue(3'd2, 32'd10, 32'd3);
      tick();
      op_valid = 1'b0;
      chk("div1_ctrl", {30'd0, MultCtrl, DivCtrl}, 32'd1);
      chk("div1_ready", 32'(op_ready), 32'd0);
      chk("div1_a", RegAOut, 32'd10);
      chk("div1_b", RegBOut, 32'd3);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("div1_hold", {30'd0, DivCtrl, op_done}, 32'd2);
      end
      DivDone = 1'b1; div_hi = 32'd1; div_lo = 32'd3;
      tick();
      DivDone = 1'b0;
      chk("div1_lo", LO, 32'd3);
      chk("div1_hi", HI, 32'd1);
      chk("div1_done", {29'd0, op_done, DivCtrl, op_ready}, 32'd4);
      tick();
      chk("div1_release", {30'd0, op_done, op_ready}, 32'd1);

      // DIV -10/3
      issue(3'd2, 32'hFFFFFFF6, 32'd3);
      tick();
      op_valid = 1'b0;
      tick();
      DivDone = 1'b1; div_hi = 32'hFFFFFFFF; div_lo = 32'hFFFFFFFD;
      tick();
      DivDone = 1'b0;
      chk("div2_lo", LO, 32'hFFFFFFFD);
      chk("div2_hi", HI, 32'hFFFFFFFF);
      tick();

      // DIV 5/0: Div0 outranks DivDone
      issue(3'd2, 32'd5, 32'd0);
      tick();
      op_valid = 1'b0;
      Div0 = 1'b1; DivDone = 1'b1; div_hi = 32'h1234; div_lo = 32'h5678;
      tick();
      Div0 = 1'b0; DivDone = 1'b0;
      chk("div0_pulses", {30'd0, div0_exc, op_done}, 32'd3);
      chk("div0_hi", HI, 32'hFFFFFFFF);
      chk("div0_lo", LO, 32'hFFFFFFFD);
      chk("div0_ctrl", 32'(DivCtrl), 32'd0);
      tick();
      chk("div0_release", {30'd0, div0_exc, op_ready}, 32'd1);

      // DIV timeout: 8 run cycles with no done
      issue(3'd2, 32'd100, 32'd7);
      tick();
      op_valid = 1'b0;
      for (int i = 0; i < 7; i++) begin
         tick();
         chk("to_wait", {30'd0, DivCtrl, timeout_err}, 32'd2);
      end
      tick();
      chk("to_pulses", {29'd0, timeout_err, op_done, DivCtrl}, 32'd6);
      chk("to_lo", LO, 32'hFFFFFFFD);
      tick();
      chk("to_release", {30'd0, timeout_err, op_ready}, 32'd1);

      // MULT 7 x -2 with MFLO held and stray DivDone during run
      issue(3'd1, 32'd7, 32'hFFFFFFFE);
      tick();
      chk("mul_ctrl", {30'd0, MultCtrl, DivCtrl}, 32'd2);
      chk("mul_b", RegBOut, 32'hFFFFFFFE);
      issue(3'd4, 32'd0, 32'd0);
      DivDone = 1'b1; div_hi = 32'hAAAA5555; div_lo = 32'h5555AAAA;
      tick();
      DivDone = 1'b0;
      chk("mul_stray", {29'd0, mf_valid, op_done, MultCtrl}, 32'd1);
      chk("mul_stray_lo", LO, 32'hFFFFFFFD);
      tick();
      MultDone = 1'b1; mult_hi = 32'hFFFFFFFF; mult_lo = 32'hFFFFFFF2;
      tick();
      MultDone = 1'b0;
      chk("mul_lo", LO, 32'hFFFFFFF2);
      chk("mul_hi", HI, 32'hFFFFFFFF);
      chk("mul_done", {29'd0, op_done, mf_valid, MultCtrl}, 32'd4);
      tick();
      chk("mul_release", {30'd0, mf_valid, op_ready}, 32'd1);
      chk("mul_hold_a", RegAOut, 32'd7);
      tick();
      op_valid = 1'b0;
      chk("mul_mflo_valid", 32'(mf_valid), 32'd1);
      chk("mul_mflo_data", mf_data, 32'hFFFFFFF2);

      // reset two cycles into DIV_RUN
      issue(3'd2, 32'd9, 32'd2);
      tick();
      op_valid = 1'b0;
      tick(); tick();
      chk("rr_running", 32'(DivCtrl), 32'd1);
      reset = 1'b0;
      #1;
      chk("rr_ctrl", 32'(DivCtrl), 32'd0);
      chk("rr_hilo", HI | LO, 32'd0);
      chk("rr_ready", 32'(op_ready), 32'd1);
      chk("rr_pulses", {27'd0, mf_valid, op_done, div0_exc, timeout_err, illegal_op}, 32'd0);
      reset = 1'b1;
      tick();
      chk("rr_quiet", {30'd0, op_done, DivCtrl}, 32'd0);

      // DIV 12/4 after reset
      issue(3'd2, 32'd12, 32'd4);
      tick();
      op_valid = 1'b0;
      tick();
      DivDone = 1'b1; div_hi = 32'd0; div_lo = 32'd3;
      tick();
      DivDone = 1'b0;
      chk("div3_lo", LO, 32'd3);
      chk("div3_hi", HI, 32'd0);
      chk("div3_done", 32'(op_done), 32'd1);
      tick();
      chk("div3_ready", 32'(op_ready), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
